regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 158 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: two result channels, each buffered in a
// small FIFO, merged round-robin onto a single registered regfile write port.

module regfile_wb_fifo #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [4:0]  in_reg,
  input  logic [31:0] in_data,
  input  logic [4:0]  query_a,
  input  logic [4:0]  query_b,
  output logic        full,
  output logic        not_empty,
  output logic [4:0]  head_reg,
  output logic [31:0] head_data,
  output logic        hit_a,
  output logic        hit_b
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt;
  logic [4:0]    reg_mem  [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic          do_pop;

  assign full      = (cnt == (PW+1)'(DEPTH));
  assign not_empty = (cnt != '0);
  assign do_pop    = pop && not_empty;
  assign head_reg  = reg_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      reg_mem[wr_ptr]  <= in_reg;
      data_mem[wr_ptr] <= in_data;
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [PW-1:0] off;
    hit_a = 1'b0;
    hit_b = 1'b0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if ({1'b0, off} < cnt) begin
        if (reg_mem[i] == query_a) hit_a = 1'b1;
        if (reg_mem[i] == query_b) hit_b = 1'b1;
      end
    end
  end
endmodule

module regfile_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_reg,
  input  logic [31:0] mem_data,
  output logic        WriteEnable,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData,
  input  logic [4:0]  QueryA,
  input  logic [4:0]  QueryB,
  output logic        BusyA,
  output logic        BusyB,
  output logic        idle
);
  logic        alu_full, alu_ne, alu_hit_a, alu_hit_b;
  logic        mem_full, mem_ne, mem_hit_a, mem_hit_b;
  logic [4:0]  alu_head_reg, mem_head_reg;
  logic [31:0] alu_head_data, mem_head_data;
  logic        alu_push, mem_push, pop_alu, pop_mem, pop_any;
  logic        contended, grant_alu, last_gnt_alu;
  logic        vld_p1;
  logic [4:0]  reg_p1;
  logic [31:0] data_p1;

  assign alu_ready = !alu_full && !rst;
  assign mem_ready = !mem_full && !rst;
  assign alu_push  = alu_valid && alu_ready;
  assign mem_push  = mem_valid && mem_ready;

  // Round-robin only matters when both queues hold work.
  assign contended = alu_ne && mem_ne;
  assign grant_alu = contended ? !last_gnt_alu : alu_ne;
  assign pop_alu   = alu_ne && grant_alu;
  assign pop_mem   = mem_ne && !grant_alu;
  assign pop_any   = pop_alu || pop_mem;

  regfile_wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk(clk), .rst(rst), .push(alu_push), .pop(pop_alu),
    .in_reg(alu_reg), .in_data(alu_data), .query_a(QueryA), .query_b(QueryB),
    .full(alu_full), .not_empty(alu_ne), .head_reg(alu_head_reg),
    .head_data(alu_head_data), .hit_a(alu_hit_a), .hit_b(alu_hit_b)
  );

  regfile_wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .clk(clk), .rst(rst), .push(mem_push), .pop(pop_mem),
    .in_reg(mem_reg), .in_data(mem_data), .query_a(QueryA), .query_b(QueryB),
    .full(mem_full), .not_empty(mem_ne), .head_reg(mem_head_reg),
    .head_data(mem_head_data), .hit_a(mem_hit_a), .hit_b(mem_hit_b)
  );

  // Stage p1: registered write-back port
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      reg_p1       <= '0;
      data_p1      <= '0;
      last_gnt_alu <= 1'b0;
    end else begin
      vld_p1 <= pop_any;
      if (pop_any) begin
        reg_p1  <= pop_alu ? alu_head_reg  : mem_head_reg;
        data_p1 <= pop_alu ? alu_head_data : mem_head_data;
      end
      if (contended) last_gnt_alu <= grant_alu;
    end
  end

  assign WriteEnable = vld_p1;
  assign WriteReg    = reg_p1;
  assign WriteData   = data_p1;

  assign BusyA = alu_hit_a || mem_hit_a || (vld_p1 && (reg_p1 == QueryA));
  assign BusyB = alu_hit_b || mem_hit_b || (vld_p1 && (reg_p1 == QueryB));
  assign idle  = !alu_ne && !mem_ne && !vld_p1;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (DEPTH = 2).

module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_reg, mem_reg;
  logic [31:0] alu_data, mem_data;
  logic        WriteEnable;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  QueryA, QueryB;
  logic        BusyA, BusyB, idle;

  int n_cmp = 0;
  int n_err = 0;

  regfile_wb_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .WriteEnable(WriteEnable), .WriteReg(WriteReg), .WriteData(WriteData),
    .QueryA(QueryA), .QueryB(QueryB), .BusyA(BusyA), .BusyB(BusyB), .idle(idle)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] r, input logic [31:0] d);
    chk({tag, "_we"},   {31'd0, WriteEnable}, 32'd1);
    chk({tag, "_reg"},  {27'd0, WriteReg}, {27'd0, r});
    chk({tag, "_data"}, WriteData, d);
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; mem_valid = 1'b0;
    alu_reg = '0; mem_reg = '0; alu_data = '0; mem_data = '0;
    QueryA = 5'd0; QueryB = 5'd31;

    // Reset state
    tick();
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    tick();
    chk("rst_we",    {31'd0, WriteEnable}, 32'd0);
    chk("rst_reg",   {27'd0, WriteReg}, 32'd0);
    chk("rst_data",  WriteData, 32'd0);
    chk("rst_idle",  {31'd0, idle}, 32'd1);
    chk("rst_busya", {31'd0, BusyA}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("post_rst_mem_ready", {31'd0, mem_ready}, 32'd1);

    // Single write
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    chk("single_we0",  {31'd0, WriteEnable}, 32'd0);
    chk("single_idle0", {31'd0, idle}, 32'd0);
    tick();
    chk_wr("single_wr", 5'd5, 32'hDEADBEEF);
    tick();
    chk("single_we_off", {31'd0, WriteEnable}, 32'd0);
    chk("single_hold",   WriteData, 32'hDEADBEEF);
    chk("single_idle",   {31'd0, idle}, 32'd1);

    // Hazard tracking
    QueryA = 5'd7; QueryB = 5'd8;
    alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'h77;
    #1;
    chk("haz_busya_pre", {31'd0, BusyA}, 32'd0);
    tick();
    alu_valid = 1'b0;
    #1;
    chk("haz_busya_q", {31'd0, BusyA}, 32'd1);
    chk("haz_busyb_q", {31'd0, BusyB}, 32'd0);
    tick();
    chk_wr("haz_wr", 5'd7, 32'h77);
    chk("haz_busya_we", {31'd0, BusyA}, 32'd1);
    chk("haz_busyb_we", {31'd0, BusyB}, 32'd0);
    tick();
    chk("haz_busya_done", {31'd0, BusyA}, 32'd0);
    chk("haz_busyb_done", {31'd0, BusyB}, 32'd0);

    // Register 0 is tracked and written like any other
    QueryA = 5'd0;
    mem_valid = 1'b1; mem_reg = 5'd0; mem_data = 32'h1234;
    tick();
    mem_valid = 1'b0;
    #1;
    chk("r0_busya_q", {31'd0, BusyA}, 32'd1);
    tick();
    chk_wr("r0_wr", 5'd0, 32'h1234);
    chk("r0_busya_we", {31'd0, BusyA}, 32'd1);
    tick();
    chk("r0_busya_done", {31'd0, BusyA}, 32'd0);

    // Contention: first contended grant goes to ALU, the next to MEM
    QueryA = 5'd30; QueryB = 5'd31;
    alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'h11;
    mem_valid = 1'b1; mem_reg = 5'd2; mem_data = 32'h22;
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    tick();
    chk_wr("cont1_first", 5'd1, 32'h11);
    tick();
    chk_wr("cont1_second", 5'd2, 32'h22);
    tick();
    chk("cont1_we_off", {31'd0, WriteEnable}, 32'd0);
    alu_valid = 1'b1; mem_valid = 1'b1;
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    tick();
    chk_wr("cont2_first", 5'd2, 32'h22);
    tick();
    chk_wr("cont2_second", 5'd1, 32'h11);
    tick();
    chk("cont2_idle", {31'd0, idle}, 32'd1);

    // Backpressure: both channels streaming, MEM fills after two accepts
    alu_valid = 1'b1; alu_reg = 5'd10; alu_data = 32'hA0;
    mem_valid = 1'b1; mem_reg = 5'd20; mem_data = 32'hB0;
    #1;
    chk("bp_mem_ready0", {31'd0, mem_ready}, 32'd1);
    tick();
    alu_data = 32'hA1; mem_data = 32'hB1;
    chk("bp_we_e1", {31'd0, WriteEnable}, 32'd0);
    chk("bp_mem_ready1", {31'd0, mem_ready}, 32'd1);
    tick();
    alu_data = 32'hA2; mem_data = 32'hB2;
    chk_wr("bp_w0", 5'd10, 32'hA0);
    chk("bp_mem_full", {31'd0, mem_ready}, 32'd0);
    chk("bp_alu_ready2", {31'd0, alu_ready}, 32'd1);
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk_wr("bp_w1", 5'd20, 32'hB0);
    chk("bp_alu_full", {31'd0, alu_ready}, 32'd0);
    tick();
    chk_wr("bp_w2", 5'd10, 32'hA1);
    tick();
    chk_wr("bp_w3", 5'd20, 32'hB1);
    tick();
    chk_wr("bp_w4", 5'd10, 32'hA2);
    tick();
    chk("bp_we_off", {31'd0, WriteEnable}, 32'd0);
    chk("bp_idle", {31'd0, idle}, 32'd1);

    // Reset mid-flight discards queued work
    alu_valid = 1'b1; alu_reg = 5'd12; alu_data = 32'hC0;
    mem_valid = 1'b1; mem_reg = 5'd13; mem_data = 32'hD0;
    QueryA = 5'd12; QueryB = 5'd13;
    tick();
    tick();
    chk("mid_we_before", {31'd0, WriteEnable}, 32'd1);
    rst = 1'b1;
    alu_data = 32'hEE; mem_data = 32'hEE;
    #1;
    chk("mid_alu_ready_rst", {31'd0, alu_ready}, 32'd0);
    chk("mid_mem_ready_rst", {31'd0, mem_ready}, 32'd0);
    tick();
    rst = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    #1;
    chk("mid_we",    {31'd0, WriteEnable}, 32'd0);
    chk("mid_idle",  {31'd0, idle}, 32'd1);
    chk("mid_busya", {31'd0, BusyA}, 32'd0);
    chk("mid_busyb", {31'd0, BusyB}, 32'd0);
    chk("mid_data",  WriteData, 32'd0);
    chk("mid_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("mid_mem_ready", {31'd0, mem_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_no_stale_we", {31'd0, WriteEnable}, 32'd0);
    end

    // Wrap-around: 8 back-to-back ALU entries
    alu_reg = 5'd3;
    for (int k = 0; k < 8; k++) begin
      alu_valid = 1'b1;
      alu_data  = 32'h100 + k;
      #1;
      chk("wrap_alu_ready", {31'd0, alu_ready}, 32'd1);
      tick();
      if (k == 0) chk("wrap_we_first", {31'd0, WriteEnable}, 32'd0);
      else        chk_wr("wrap_wr", 5'd3, 32'h100 + k - 1);
    end
    alu_valid = 1'b0;
    tick();
    chk_wr("wrap_last", 5'd3, 32'h107);
    tick();
    chk("wrap_idle", {31'd0, idle}, 32'd1);

    // After reset the first contended grant is ALU again
    alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'h31;
    mem_valid = 1'b1; mem_reg = 5'd2; mem_data = 32'h32;
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    tick();
    chk_wr("rr_reset_first", 5'd1, 32'h31);
    tick();
    chk_wr("rr_reset_second", 5'd2, 32'h32);
    tick();
    chk("rr_idle", {31'd0, idle}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
